// File: rtl/pipe_fwd_ctrl.sv
// Hazard/forwarding controller beside decode: operands and stall are combinational from tracked stages.
// Tracking entries shift every cycle without backpressure; a stall holds decode and injects a bubble into stage 0.
module pipe_fwd_ctrl #(
  parameter int DEPTH      = 3,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int LATE_READY = 1,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic                    id_we,
  input  logic [ADDR_W-1:0]       id_dst,
  input  logic                    id_late,
  input  logic [ADDR_W-1:0]       id_src_a,
  input  logic [ADDR_W-1:0]       id_src_b,
  input  logic                    id_use_a,
  input  logic                    id_use_b,
  input  logic [DATA_W-1:0]       rf_a,
  input  logic [DATA_W-1:0]       rf_b,
  input  logic                    flush,
  input  logic [DEPTH*DATA_W-1:0] stage_res,
  output logic [DATA_W-1:0]       opnd_a,
  output logic [DATA_W-1:0]       opnd_b,
  output logic                    stall,
  output logic [DEPTH-1:0]        stage_valid,
  output logic [CNT_W-1:0]        stall_cnt
);

  logic [DEPTH-1:0]  r_v;
  logic [DEPTH-1:0]  r_we;
  logic [DEPTH-1:0]  r_late;
  logic [ADDR_W-1:0] r_dst [DEPTH];
  logic [CNT_W-1:0]  r_cnt;

  logic              w_hit_a, w_hit_b;
  logic              w_wait_a, w_wait_b;
  logic [DATA_W-1:0] w_res_a, w_res_b;
  logic              w_stall;
  logic              w_insert;

  // Scan oldest to youngest so the lowest matching stage is the final winner.
  always_comb begin
    w_hit_a  = 1'b0;
    w_hit_b  = 1'b0;
    w_wait_a = 1'b0;
    w_wait_b = 1'b0;
    w_res_a  = '0;
    w_res_b  = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (r_v[k] && r_we[k] && (r_dst[k] != '0)) begin
        if (id_use_a && (id_src_a != '0) && (r_dst[k] == id_src_a)) begin
          w_hit_a  = 1'b1;
          w_wait_a = r_late[k] && (k < LATE_READY);
          w_res_a  = stage_res[k*DATA_W +: DATA_W];
        end
        if (id_use_b && (id_src_b != '0) && (r_dst[k] == id_src_b)) begin
          w_hit_b  = 1'b1;
          w_wait_b = r_late[k] && (k < LATE_READY);
          w_res_b  = stage_res[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign w_stall  = (w_wait_a || w_wait_b) && id_valid && !flush;
  assign w_insert = id_valid && !w_stall && !flush;

  assign opnd_a      = (w_hit_a && !w_wait_a) ? w_res_a : rf_a;
  assign opnd_b      = (w_hit_b && !w_wait_b) ? w_res_b : rf_b;
  assign stall       = w_stall;
  assign stage_valid = r_v;
  assign stall_cnt   = r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v    <= '0;
      r_we   <= '0;
      r_late <= '0;
      for (int k = 0; k < DEPTH; k++) r_dst[k] <= '0;
      r_cnt  <= '0;
    end else begin
      for (int k = DEPTH-1; k > 0; k--) begin
        r_v[k]    <= r_v[k-1];
        r_we[k]   <= r_we[k-1];
        r_late[k] <= r_late[k-1];
        r_dst[k]  <= r_dst[k-1];
      end
      r_v[0]    <= w_insert;
      r_we[0]   <= id_we;
      r_late[0] <= id_late;
      r_dst[0]  <= id_dst;
      if (w_stall && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipe_fwd_ctrl.md
# pipe_fwd_ctrl

Parametrised hazard and forwarding controller for the in-order MIPS pipeline, placed beside decode. It tracks each in-flight instruction's destination register, write-enable and result-latency class across DEPTH post-decode stages. From that state it selects forwarded operand values for the instruction in decode, and it raises a load-use stall that holds fetch/decode while injecting a bubble into execute. It is the successor to the fixed EXE/MEM stall and bypass logic: stage count, widths and result latency are generic, and it adds flush and stall accounting.

## Interface
- DEPTH, 3, tracked stages after decode; stage 0 = EXE, DEPTH-1 = WB; legal 2..8
- DATA_W, 32, operand/result width
- ADDR_W, 5, register address width
- LATE_READY, 1, first stage index at which a late (load/mfc0-class) result is valid; legal 1..DEPTH-1
- CNT_W, 16, stall counter width

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, synchronous, active-high
- id_valid  in  1  decode holds a real instruction
- id_we  in  1  decode instruction writes the register file
- id_dst  in  ADDR_W  decode destination register
- id_late  in  1  decode instruction's result is available only from stage LATE_READY
- id_src_a, id_src_b  in  ADDR_W  decode source registers
- id_use_a, id_use_b  in  1  source actually read
- rf_a, rf_b  in  DATA_W  register-file read values
- flush  in  1  branch taken: decode instruction is squashed
- stage_res  in  DEPTH*DATA_W  result leaving each stage; slice k = stage k
- opnd_a, opnd_b  out  DATA_W  forwarded operands
- stall  out  1  hold PC and IF/ID registers this cycle
- stage_valid  out  DEPTH  per-stage occupancy
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Each stage k has the tracking entry {v, we, dst, late}.
- A write is effective only when v=1, we=1 and dst≠0.
- Each rising edge, the entries shift: k takes k-1 for k=1..DEPTH-1.
- Stage 0 loads the decode fields when the insert condition holds: id_valid=1, stall=0 and flush=0. Otherwise stage 0 loads a bubble (v=0).
- Downstream stages never stall; the shift is unconditional.
- Match_x(k) is true when use_x=1, src_x≠0, entry k has an effective write, and entry k's dst = src_x.
- The youngest match (lowest k) wins.
- Stall condition: some matched winner has late=1 and k < LATE_READY. When it holds, stall=1 if id_valid=1 and flush=0.
- Operand selection, evaluated independently for a and b:
  - If the winner exists and is not stalling, opnd_x = stage_res[k].
  - Otherwise opnd_x = rf_x.
  - Register 0 always yields rf_x, never a forwarded value.
- stall, opnd_a and opnd_b are combinational from the registered entries plus the decode inputs.
- stall_cnt increments on every edge with stall=1 and saturates at all-ones.
- flush has priority over stall. A squashed instruction never stalls and never enters the pipe.

## Timing
- Reset drives every entry v=0 and stall_cnt=0. Consequently stall=0, stage_valid=0, and opnd_x=rf_x.
- An instruction inserted at edge n occupies stage k during cycle n+k. It leaves after stage DEPTH-1.
- Load-use with LATE_READY=1: stall is high for exactly 1 cycle. With LATE_READY=L, a dependent instruction immediately behind a load stalls L cycles.
- Stage DEPTH-1 is forwarded, so same-cycle WB→decode needs no register-file write-through.
- Simultaneous a/b hazards on different producers: stall persists until both are resolved. The count is the maximum of the two, not the sum.
- Reset asserted mid-operation clears all entries at that edge. Results in flight are discarded and no stall persists.
- A stall with id_valid=0 cannot occur. A matching entry whose we=0, or whose dst=0, never forwards and never stalls.

## Test plan
- Reset: pulse reset with all entries previously valid -> next cycle stage_valid=0, stall=0, stall_cnt=0, opnd_a=rf_a.
- ALU chain: addu $3 inserted; next decode reads $3 with stage_res[0]=0x0000_00AA -> opnd_a=0xAA, stall=0. One cycle later, stage_res[1]=0xAA -> still 0xAA.
- Load-use (DEPTH=3, LATE_READY=1): lw $4, then a reader of $4 -> stall=1 for one cycle; a bubble appears at stage 0 (stage_valid=3'b010). Next cycle opnd_b=stage_res[1]=0x1234_5678; stall_cnt=1.
- Priority: $5 is written by stage 2 (0x11) and stage 0 (0x22) -> opnd_a=0x22. Source $0 with a stage writing $0 (0xFF) -> opnd_a=rf_a.
- Flush: flush=1 together with a load-use match -> stall=0, stage 0 gets a bubble, stall_cnt unchanged.
- Generics: DEPTH=5, LATE_READY=3, load then an immediate reader -> stall high for 3 consecutive cycles, then the operand comes from stage_res[3]. Force stall_cnt to saturation -> it holds all-ones.
